uart_rx_fifo: RTL and testbench

//  Receive buffer between uart_core (RX side) and uart_wrapper on the register bus.
//  - Drains each byte from the core's single-byte RX holding register into a FIFO, so the CPU can fall behind by DEPTH bytes.
//  - Gives the wrapper the same data_rx/have_data_rx/data_rx_ack handshake the core provides, plus level and sticky overrun status.

---
 rtl/uart_rx_fifo_pkg.sv | 7 +
 rtl/uart_rx_fifo_regfile.sv | 21 ++
 rtl/uart_rx_fifo.sv | 124 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART RX path (data width, default FIFO depth, status bit positions).
package uart_rx_fifo_pkg;
    localparam int UART_DATA_WIDTH            = 8;
    localparam int UART_RX_FIFO_DEPTH_DEFAULT = 8;
    localparam int RXSTAT_HAVE                = 0;
    localparam int RXSTAT_OVERRUN             = 1;
endpackage

// File: rtl/uart_rx_fifo_regfile.sv
// DEPTH x WIDTH flop array for the RX FIFO: one synchronous write port, one combinational read port.
module fifo_regfile #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is left unreset; have_data_rx qualifies every read.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// RX buffer between uart_core and uart_wrapper: capture FSM, pointers, level and sticky overrun.
// Optional saturating dropped-byte counter enabled by UART_RX_FIFO_DROP_COUNT_EN.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH_DEFAULT,
    parameter int WIDTH = UART_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           core_data_rx,
    input  logic                       core_have_data_rx,
    output logic                       core_data_rx_ack,
    output logic [WIDTH-1:0]           data_rx,
    output logic                       have_data_rx,
    input  logic                       data_rx_ack,
    input  logic                       flush,
    input  logic                       overrun_clr,
    output logic                       overrun,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [7:0]                 drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_LOW = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          ack_q, ack_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overrun_q, overrun_d;
    logic          capture, pop, push, drop;

    assign capture = (state_q == ST_IDLE) && core_have_data_rx;
    assign pop     = data_rx_ack && (level_q != '0);
    assign push    = capture && ((level_q < LW'(DEPTH)) || pop);
    // A byte thrown away by a same-cycle flush is not an overrun.
    assign drop    = capture && !push && !flush;

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE:     if (core_have_data_rx) begin
                             ack_d   = 1'b1;
                             state_d = ST_WAIT_LOW;
                         end
            default:     if (!core_have_data_rx) state_d = ST_IDLE;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      level_d = level_q + LW'(1);
            else if (pop && !push) level_d = level_q - LW'(1);
        end

        if (drop)             overrun_d = 1'b1;
        else if (overrun_clr) overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    fifo_regfile #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_regfile (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr_q),
        .wdata (core_data_rx),
        .raddr (rd_ptr_q),
        .rdata (data_rx)
    );

`ifdef UART_RX_FIFO_DROP_COUNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop)             drop_cnt_d = overrun_clr ? 8'h01 :
                                           (drop_cnt_q == 8'hFF) ? 8'hFF : drop_cnt_q + 8'h01;
        else if (overrun_clr) drop_cnt_d = 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= 8'h00;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'h00;
`endif

    assign core_data_rx_ack = ack_q;
    assign have_data_rx     = (level_q != '0);
    assign level            = level_q;
    assign overrun          = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] core_data_rx;
    logic             core_have_data_rx;
    logic             core_data_rx_ack;
    logic [WIDTH-1:0] data_rx;
    logic             have_data_rx;
    logic             data_rx_ack;
    logic             flush;
    logic             overrun_clr;
    logic             overrun;
    logic [3:0]       level;
    logic [7:0]       drop_count;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .core_data_rx      (core_data_rx),
        .core_have_data_rx (core_have_data_rx),
        .core_data_rx_ack  (core_data_rx_ack),
        .data_rx           (data_rx),
        .have_data_rx      (have_data_rx),
        .data_rx_ack       (data_rx_ack),
        .flush             (flush),
        .overrun_clr       (overrun_clr),
        .overrun           (overrun),
        .level             (level),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: byte queue, sticky flag, drop tally, and whether the
    // core's current offer has already been taken.
    logic [7:0] mq[$];
    bit         m_ovr;
    int         m_drops;
    bit         m_armed;
    bit         m_ack;

    task automatic model_reset();
        mq.delete();
        m_ovr = 0; m_drops = 0; m_armed = 1; m_ack = 0;
    endtask

    task automatic model_step();
        bit do_pop, do_cap, dropped;
        do_pop  = data_rx_ack && (mq.size() > 0);
        do_cap  = m_armed && core_have_data_rx;
        dropped = 0;
        if (flush) begin
            mq.delete();
        end else begin
            if (do_cap && mq.size() == DEPTH && !do_pop) dropped = 1;
            if (do_pop) void'(mq.pop_front());
            if (do_cap && !dropped) mq.push_back(core_data_rx);
        end
        if (dropped) begin
            m_ovr   = 1;
            m_drops = overrun_clr ? 1 : (m_drops < 255 ? m_drops + 1 : 255);
        end else if (overrun_clr) begin
            m_ovr = 0; m_drops = 0;
        end
        m_ack = do_cap;
        if (do_cap)                 m_armed = 0;
        else if (!core_have_data_rx) m_armed = 1;
    endtask

    task automatic check_all();
        chk("have", 32'(have_data_rx), 32'(mq.size() != 0));
        chk("level", 32'(level), 32'(mq.size()));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("core_ack", 32'(core_data_rx_ack), 32'(m_ack));
`ifdef UART_RX_FIFO_DROP_COUNT_EN
        chk("drop_count", 32'(drop_count), 32'(m_drops));
`else
        chk("drop_count", 32'(drop_count), 32'd0);
`endif
        if (mq.size() != 0) chk("data", 32'(data_rx), 32'(mq[0]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic send_byte(input logic [7:0] b);
        core_have_data_rx = 1; core_data_rx = b;
        cycle();
        core_have_data_rx = 0;
        cycle();
    endtask

    task automatic pop_one(output logic [7:0] b);
        b = data_rx;
        data_rx_ack = 1;
        cycle();
        data_rx_ack = 0;
    endtask

    logic [7:0] got;
    int         acks;

    initial begin
        rst_n = 0; core_data_rx = '0; core_have_data_rx = 0;
        data_rx_ack = 0; flush = 0; overrun_clr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk); rst_n = 1;

        // 1: single byte
        core_have_data_rx = 1; core_data_rx = 8'hA5;
        cycle();
        chk("t1_ack", 32'(core_data_rx_ack), 32'd1);
        chk("t1_data", 32'(data_rx), 32'hA5);
        chk("t1_level", 32'(level), 32'd1);
        core_have_data_rx = 0;
        cycle();
        pop_one(got);
        chk("t1_level0", 32'(level), 32'd0);

        // 2: fill and overrun
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        chk("t2_full", 32'(level), 32'd8);
        chk("t2_noovr", 32'(overrun), 32'd0);
        send_byte(8'h09);
        chk("t2_ovr", 32'(overrun), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            pop_one(got);
            chk("t2_order", 32'(got), 32'(i));
        end
        overrun_clr = 1; cycle(); overrun_clr = 0;

        // 3: full + simultaneous pop and push
        for (int i = 1; i <= 8; i++) send_byte(8'(8'h10 + i));
        core_have_data_rx = 1; core_data_rx = 8'h55; data_rx_ack = 1;
        cycle();
        core_have_data_rx = 0; data_rx_ack = 0;
        cycle();
        chk("t3_noovr", 32'(overrun), 32'd0);
        chk("t3_level", 32'(level), 32'd8);
        for (int i = 0; i < 8; i++) pop_one(got);
        chk("t3_last", 32'(got), 32'h55);

        // 5: held core_have for 10 cycles
        acks = 0;
        core_have_data_rx = 1; core_data_rx = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (core_data_rx_ack) acks++;
        end
        core_have_data_rx = 0;
        cycle();
        chk("t5_acks", 32'(acks), 32'd1);
        chk("t5_level", 32'(level), 32'd1);
        pop_one(got);

        // 6: flush with same-cycle push, then reset mid-capture
        for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i));
        flush = 1; core_have_data_rx = 1; core_data_rx = 8'hEE;
        cycle();
        flush = 0; core_have_data_rx = 0;
        cycle();
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_have", 32'(have_data_rx), 32'd0);
        chk("t6_ovr", 32'(overrun), 32'd0);
        send_byte(8'h77);
        core_have_data_rx = 1; core_data_rx = 8'h99;
        cycle();
        #1 rst_n = 0;
        #1;
        model_reset();
        chk("t6_rst_ack", 32'(core_data_rx_ack), 32'd0);
        chk("t6_rst_have", 32'(have_data_rx), 32'd0);
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_ovr", 32'(overrun), 32'd0);
        chk("t6_rst_drops", 32'(drop_count), 32'd0);
        @(negedge clk); rst_n = 1;
        cycle();
        chk("t6_recap", 32'(data_rx), 32'h99);
        core_have_data_rx = 0;
        cycle();

        // 4: random traffic, pop rate changes every 100 cycles
        for (int i = 0; i < 600; i++) begin
            int pop_pct;
            pop_pct = ((i / 100) % 2) ? 80 : 30;
            data_rx_ack = ($urandom_range(99) < pop_pct);
            flush       = ($urandom_range(59) == 0);
            overrun_clr = ($urandom_range(19) == 0);
            if (core_data_rx_ack)                       core_have_data_rx = 0;
            else if (!core_have_data_rx && $urandom_range(1)) begin
                core_have_data_rx = 1;
                core_data_rx      = 8'($urandom);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
